// File: rtl/sw_pkg.sv
// Shared types and arithmetic helpers for the Smith-Waterman scoring engine.
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'b10;
  localparam logic [1:0] BASE_G = 2'b11;
  localparam logic [1:0] BASE_T = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} sw_state_e;

  // Biased zero for a score of width w.
  function automatic logic [31:0] sw_zero(input int w);
    return 32'(1) << (w - 1);
  endfunction

  // Biased add/subtract clamped to [zero, 2**w-1]; callers size-cast the result.
  function automatic logic [31:0] sat_addsub(input logic [31:0] a, input logic [31:0] b,
                                             input logic sub, input int w);
    logic [32:0] s, z, mx;
    z  = 33'(1) << (w - 1);
    mx = (33'(1) << w) - 33'(1);
    if (sub) begin
      s = ({1'b0, a} < z + {1'b0, b}) ? z : {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, b};
      if (s > mx) s = mx;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/sw_pe_chain.sv
// Systolic chain of affine-gap Smith-Waterman PEs; PE i holds query base i.
// The whole chain advances only on shift, so stalls never break alignment.
module sw_pe_chain
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int MAX_QLEN    = 128,
  parameter int POS_W       = 16,
  parameter int IW          = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          shift,
  input  logic                          inj,
  input  logic [1:0]                    t_base,
  input  logic [POS_W-1:0]              t_idx,
  input  logic [MAX_QLEN-1:0][1:0]      query,
  input  logic [MAX_QLEN-1:0]           mask,
  input  logic [SCORE_WIDTH-1:0]        match,
  input  logic [SCORE_WIDTH-1:0]        mismatch,
  input  logic [SCORE_WIDTH-1:0]        gap_open,
  input  logic [SCORE_WIDTH-1:0]        gap_extend,
  input  logic [IW-1:0]                 sel,
  output logic [SCORE_WIDTH-1:0]        sel_h,
  output logic                          sel_vld,
  output logic [POS_W-1:0]              sel_idx
);

  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(sw_zero(SCORE_WIDTH));

  logic [SCORE_WIDTH-1:0] h_q [MAX_QLEN];
  logic [SCORE_WIDTH-1:0] e_q [MAX_QLEN];
  logic [SCORE_WIDTH-1:0] f_q [MAX_QLEN];
  logic [SCORE_WIDTH-1:0] d_q [MAX_QLEN];
  logic [1:0]             t_q [MAX_QLEN];
  logic [POS_W-1:0]       x_q [MAX_QLEN];
  logic                   v_q [MAX_QLEN];

  for (genvar i = 0; i < MAX_QLEN; i++) begin : g_pe
    logic [SCORE_WIDTH-1:0] h_in, f_in, d_new, e_new, f_new, h_new;
    logic [SCORE_WIDTH-1:0] eo, ee, fo, fe;
    logic [1:0]             t_in;
    logic [POS_W-1:0]       x_in;
    logic                   v_in;
    logic                   hit;

    if (i == 0) begin : g_head
      assign h_in = ZERO;
      assign f_in = ZERO;
      assign t_in = t_base;
      assign x_in = t_idx;
      assign v_in = inj;
    end else begin : g_link
      assign h_in = h_q[i-1];
      assign f_in = f_q[i-1];
      assign t_in = t_q[i-1];
      assign x_in = x_q[i-1];
      assign v_in = v_q[i-1];
    end

    // d_q holds H(i-1,j-1), h_q/e_q hold this PE's previous column, f_in is F(i-1,j).
    always_comb begin
      hit   = (query[i] == t_in);
      d_new = SCORE_WIDTH'(sat_addsub(32'(d_q[i]), hit ? 32'(match) : 32'(mismatch), !hit, SCORE_WIDTH));
      eo    = SCORE_WIDTH'(sat_addsub(32'(h_q[i]), 32'(gap_open),   1'b1, SCORE_WIDTH));
      ee    = SCORE_WIDTH'(sat_addsub(32'(e_q[i]), 32'(gap_extend), 1'b1, SCORE_WIDTH));
      fo    = SCORE_WIDTH'(sat_addsub(32'(h_in),   32'(gap_open),   1'b1, SCORE_WIDTH));
      fe    = SCORE_WIDTH'(sat_addsub(32'(f_in),   32'(gap_extend), 1'b1, SCORE_WIDTH));
      e_new = (eo > ee) ? eo : ee;
      f_new = (fo > fe) ? fo : fe;
      // Every term is already floored at ZERO, so the local-alignment floor is implicit.
      h_new = d_new;
      if (e_new > h_new) h_new = e_new;
      if (f_new > h_new) h_new = f_new;
    end

    always_ff @(posedge clk) begin
      if (!rst || clr) begin
        h_q[i] <= ZERO;
        e_q[i] <= ZERO;
        f_q[i] <= ZERO;
        d_q[i] <= ZERO;
        t_q[i] <= '0;
        x_q[i] <= '0;
        v_q[i] <= 1'b0;
      end else if (shift) begin
        v_q[i] <= v_in & ~mask[i];
        if (v_in && !mask[i]) begin
          h_q[i] <= h_new;
          e_q[i] <= e_new;
          f_q[i] <= f_new;
          d_q[i] <= h_in;
          t_q[i] <= t_in;
          x_q[i] <= x_in;
        end
      end
    end
  end

  assign sel_h   = h_q[sel];
  assign sel_vld = v_q[sel];
  assign sel_idx = x_q[sel];

endmodule

// File: rtl/sw_score_engine.sv
// Smith-Waterman engine: serial query load, streamed target, drain, best-score result.
// Define SW_POS_TRACK_EN to report the target position of the best score.
module sw_score_engine
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int MAX_QLEN    = 128,
  parameter int QLEN_W      = $clog2(MAX_QLEN + 1),
  parameter int POS_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [QLEN_W-1:0]      query_len,
  input  logic                   q_valid,
  input  logic [1:0]             q_base,
  output logic                   q_ready,
  input  logic                   t_valid,
  input  logic [1:0]             t_base,
  input  logic                   t_last,
  output logic                   t_ready,
  input  logic [SCORE_WIDTH-1:0] match,
  input  logic [SCORE_WIDTH-1:0] mismatch,
  input  logic [SCORE_WIDTH-1:0] gap_open,
  input  logic [SCORE_WIDTH-1:0] gap_extend,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic [POS_W-1:0]       res_pos,
  output logic                   busy
);

  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(sw_zero(SCORE_WIDTH));
  localparam int IW = (MAX_QLEN > 1) ? $clog2(MAX_QLEN) : 1;
  localparam int DW = QLEN_W + 1;

  sw_state_e state, state_nx;

  logic [QLEN_W-1:0]          qlen, qlen_in, qlen_m1, k;
  logic [DW-1:0]              dcnt;
  logic [MAX_QLEN-1:0][1:0]   qbuf;
  logic [MAX_QLEN-1:0]        mask;
  logic [POS_W-1:0]           tpos;
  logic                       q_hs, t_hs, shift, start_go;
  logic [SCORE_WIDTH-1:0]     sel_h, tap_h, best;
  logic [POS_W-1:0]           sel_idx, tap_idx, best_pos;
  logic                       sel_vld, tap_vld;

  assign q_ready   = (state == LOAD);
  assign t_ready   = (state == RUN);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_score = best;
  assign res_pos   = best_pos;

  assign q_hs     = q_valid & q_ready;
  assign t_hs     = t_valid & t_ready;
  assign start_go = (state == IDLE) & start;
  assign qlen_in  = (query_len > QLEN_W'(MAX_QLEN)) ? QLEN_W'(MAX_QLEN) : query_len;
  assign qlen_m1  = qlen - QLEN_W'(1);
  // DRAIN spends qlen cycles shifting bubbles, then two cycles flushing the tap and tracker.
  assign shift    = t_hs | ((state == DRAIN) && (dcnt < DW'(qlen)));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (query_len == '0) ? DONE : LOAD;
      LOAD:    if (q_hs && (k == qlen_m1)) state_nx = RUN;
      RUN:     if (t_hs && t_last) state_nx = DRAIN;
      DRAIN:   if (dcnt == DW'(qlen) + DW'(1)) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_QLEN; i++) mask[i] = (i >= int'(qlen));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      qlen     <= '0;
      k        <= '0;
      dcnt     <= '0;
      qbuf     <= '0;
      tap_vld  <= 1'b0;
      tap_h    <= ZERO;
      tap_idx  <= '0;
      best     <= ZERO;
      best_pos <= '0;
    end else begin
      tap_vld <= shift & sel_vld;
      tap_h   <= sel_h;
      tap_idx <= sel_idx;
      dcnt    <= (state == DRAIN) ? dcnt + DW'(1) : '0;
      if (q_hs) begin
        qbuf[k[IW-1:0]] <= q_base;
        k               <= k + QLEN_W'(1);
      end
      if (start_go) begin
        qlen     <= qlen_in;
        k        <= '0;
        best     <= ZERO;
        best_pos <= '0;
      end else if (tap_vld && (tap_h > best)) begin
        best     <= tap_h;
        best_pos <= tap_idx;
      end
    end
  end

`ifdef SW_POS_TRACK_EN
  always_ff @(posedge clk) begin
    if (!rst || start_go)        tpos <= '0;
    else if (t_hs && tpos != '1) tpos <= tpos + POS_W'(1);
  end
`else
  assign tpos = '0;
`endif

  sw_pe_chain #(
    .SCORE_WIDTH(SCORE_WIDTH),
    .MAX_QLEN   (MAX_QLEN),
    .POS_W      (POS_W),
    .IW         (IW)
  ) u_chain (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_go),
    .shift     (shift),
    .inj       (t_hs),
    .t_base    (t_base),
    .t_idx     (tpos),
    .query     (qbuf),
    .mask      (mask),
    .match     (match),
    .mismatch  (mismatch),
    .gap_open  (gap_open),
    .gap_extend(gap_extend),
    .sel       (qlen_m1[IW-1:0]),
    .sel_h     (sel_h),
    .sel_vld   (sel_vld),
    .sel_idx   (sel_idx)
  );

endmodule

// File: tb/tb_sw_score_engine.sv
// Randomized bench for sw_score_engine against a dynamic-programming reference.
module tb_sw_score_engine;
  import sw_pkg::*;

  localparam int SW = 12;
  localparam int MQ = 128;
  localparam int QW = $clog2(MQ + 1);
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [QW-1:0] query_len = '0;
  logic q_valid = 1'b0, t_valid = 1'b0, t_last = 1'b0, res_ready = 1'b0;
  logic [1:0] q_base = '0, t_base = '0;
  logic [SW-1:0] match = '0, mismatch = '0, gap_open = '0, gap_extend = '0;
  logic q_ready, t_ready, res_valid, busy;
  logic [SW-1:0] res_score;
  logic [PW-1:0] res_pos;

  int n_chk = 0, n_err = 0, cyc = 0;
  int mt, mm, go, ge;
  logic [1:0] qry[$], tgt[$];

  sw_score_engine dut (
    .clk(clk), .rst(rst), .start(start), .query_len(query_len),
    .q_valid(q_valid), .q_base(q_base), .q_ready(q_ready),
    .t_valid(t_valid), .t_base(t_base), .t_last(t_last), .t_ready(t_ready),
    .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
    .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score),
    .res_pos(res_pos), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int clip(input int x);
    return (x < 0) ? 0 : ((x > 2047) ? 2047 : x);
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int exp_pos(input int p);
`ifdef SW_POS_TRACK_EN
    return p;
`else
    return 0 * p;
`endif
  endfunction

  // Affine-gap DP over the query x target matrix; best taken from the last query row.
  function automatic void model(input int ql, output int sc, output int ps);
    int hc[MQ], ec[MQ];
    int n, best, d, e, f, h, hup, fup, dsrc, s;
    n = (ql > MQ) ? MQ : ql;
    for (int i = 0; i < MQ; i++) begin hc[i] = 0; ec[i] = 0; end
    best = 0; ps = 0;
    for (int j = 0; j < tgt.size(); j++) begin
      hup = 0; fup = 0; dsrc = 0;
      for (int i = 0; i < n; i++) begin
        s = (qry[i] == tgt[j]) ? mt : -mm;
        d = clip(dsrc + s);
        e = clip(mx(hc[i] - go, ec[i] - ge));
        f = clip(mx(hup - go, fup - ge));
        h = mx(0, mx(d, mx(e, f)));
        dsrc = hc[i]; hc[i] = h; ec[i] = e; hup = h; fup = f;
      end
      if (n > 0 && hup > best) begin best = hup; ps = j; end
    end
    sc = best + 2048;
  endfunction

  task automatic set_scores(input int a, input int b, input int c, input int d);
    mt = a; mm = b; go = c; ge = d;
    match = SW'(a); mismatch = SW'(b); gap_open = SW'(c); gap_extend = SW'(d);
  endtask

  task automatic run_job(input int ql_req, input bit gappy, input int hold,
                         output int sc, output int ps, output int lat, output int nq, output int nt);
    int g, hs;
    @(negedge clk); start = 1'b1; query_len = QW'(ql_req);
    @(negedge clk); start = 1'b0;
    nq = 0; g = 0;
    while (q_ready && g < 2000) begin
      q_valid = ($urandom_range(0, 3) != 0);
      q_base  = qry[nq];
      if (q_valid) nq++;
      @(negedge clk); g++;
    end
    q_valid = 1'b0;
    nt = 0; g = 0; hs = cyc;
    while (t_ready && g < 2000) begin
      t_valid = !(gappy && (g % 2 == 1));
      t_base  = tgt[nt];
      t_last  = (nt == tgt.size() - 1);
      if (t_valid) nt++;
      @(negedge clk); g++;
      if (t_valid && t_last) hs = cyc;
    end
    t_valid = 1'b0; t_last = 1'b0;
    g = 0;
    while (!res_valid && g < 1000) begin @(negedge clk); g++; end
    chk("res_valid_seen", res_valid, 1);
    lat = cyc - hs; sc = res_score; ps = res_pos;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_score", res_score, sc);
      chk("hold_pos", res_pos, ps);
    end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    chk("idle_after_ack", busy, 0);
  endtask

  task automatic set_acgt();
    qry = {BASE_A, BASE_C, BASE_G, BASE_T};
    tgt = {BASE_A, BASE_C, BASE_G, BASE_T};
  endtask

  initial begin
    int sc, ps, lat, nq, nt, es, ep, ql;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_q_ready", q_ready, 0);
    chk("rst_t_ready", t_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_score", res_score, 2048);
    chk("rst_pos", res_pos, 0);
    rst = 1'b1;

    set_scores(2, 1, 3, 1); set_acgt();
    run_job(4, 0, 0, sc, ps, lat, nq, nt);
    model(4, es, ep);
    chk("acgt_score", sc, 2056); chk("acgt_model", sc, es);
    chk("acgt_pos", ps, exp_pos(3)); chk("acgt_lat", lat, 6);

    qry = {BASE_A, BASE_A, BASE_A, BASE_A}; tgt = {BASE_T, BASE_T, BASE_T, BASE_T};
    run_job(4, 0, 0, sc, ps, lat, nq, nt);
    chk("aaaa_score", sc, 2048); chk("aaaa_pos", ps, 0);

    set_acgt();
    run_job(4, 1, 5, sc, ps, lat, nq, nt);
    chk("gappy_score", sc, 2056); chk("gappy_pos", ps, exp_pos(3)); chk("gappy_lat", lat, 6);

    run_job(0, 0, 1, sc, ps, lat, nq, nt);
    chk("zero_score", sc, 2048); chk("zero_lat", lat, 0);
    chk("zero_nq", nq, 0); chk("zero_nt", nt, 0);

    qry.delete(); tgt.delete();
    for (int i = 0; i < 200; i++) qry.push_back(2'($urandom_range(0, 3)));
    for (int i = 0; i < 6; i++) tgt.push_back(2'($urandom_range(0, 3)));
    tgt[0] = qry[127];
    run_job(200, 0, 0, sc, ps, lat, nq, nt);
    model(200, es, ep);
    chk("clamp_nq", nq, 128); chk("clamp_score", sc, es);
    chk("clamp_pos", ps, exp_pos(ep)); chk("clamp_lat", lat, 130);

    // Abort a job after two target bases, then rerun it from scratch.
    set_acgt();
    @(negedge clk); start = 1'b1; query_len = QW'(4);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin q_valid = 1'b1; q_base = qry[i]; @(negedge clk); end
    q_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin t_valid = 1'b1; t_base = tgt[i]; @(negedge clk); end
    t_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0); chk("midrst_t_ready", t_ready, 0);
    chk("midrst_res_valid", res_valid, 0); chk("midrst_score", res_score, 2048);
    rst = 1'b1;
    run_job(4, 0, 0, sc, ps, lat, nq, nt);
    chk("rerun_score", sc, 2056); chk("rerun_pos", ps, exp_pos(3)); chk("rerun_lat", lat, 6);

    set_scores(1500, 1, 3, 1);
    qry = {BASE_A, BASE_A, BASE_A}; tgt = {BASE_A, BASE_A, BASE_A};
    run_job(3, 0, 0, sc, ps, lat, nq, nt);
    chk("sat_score", sc, 4095); chk("sat_pos", ps, exp_pos(2));

    for (int r = 0; r < 10; r++) begin
      set_scores($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      ql = $urandom_range(1, 12);
      qry.delete(); tgt.delete();
      for (int i = 0; i < ql; i++) qry.push_back(2'($urandom_range(0, 3)));
      for (int i = 0; i < $urandom_range(1, 16); i++) tgt.push_back(2'($urandom_range(0, 3)));
      run_job(ql, 1'($urandom_range(0, 1)), $urandom_range(0, 2), sc, ps, lat, nq, nt);
      model(ql, es, ep);
      chk("rnd_score", sc, es); chk("rnd_pos", ps, exp_pos(ep));
      chk("rnd_lat", lat, ql + 2); chk("rnd_nq", nq, ql);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
